acq_mode_sequencer: RTL and testbench
=====================================

Name: acq_mode_sequencer

Overview:
Parametrised successor to the acquisition-mode switcher. It arbitrates among NUM_MODES test engines (normal ACQ, sweep ACQ, S-curve, ADC, and any added later). One shared USB start/stop level controls the active engine; the block latches the selected mode for the whole run and sequences its start/stop. It multiplexes that engine's data stream into the USB external FIFO and adds flush, timeout, overflow and word-count behaviour the fixed switcher lacks.

Parameters:
NUM_MODES, 4, number of attached test engines (2..16)
MODE_W, 2, width of mode index; must satisfy 2**MODE_W >= NUM_MODES
DATA_WIDTH, 16, word width of engine data and USB FIFO data
FLUSH_CYCLES, 16, cycles data is still accepted after stop/done
TIMEOUT_W, 24, width of the idle-data timeout counter
COUNT_W, 32, width of the transferred-word counter

Ports:
Clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
ModeSelect  in  MODE_W  requested engine index, sampled at run start only
UsbStartStop  in  1  level from USB host; rising edge starts, falling edge stops
TimeoutMax  in  TIMEOUT_W  max cycles without data in RUN; 0 disables timeout
ModeStartStop  out  NUM_MODES  one-hot start/stop level to engines
ModeDone  in  NUM_MODES  per-engine done pulse/level
ModeData  in  NUM_MODES*DATA_WIDTH  concatenated engine data, engine i at [i*DATA_WIDTH +: DATA_WIDTH]
ModeData_en  in  NUM_MODES  per-engine data valid
UsbDataFifoFull  in  1  USB external FIFO full
OutUsbFifoData  out  DATA_WIDTH  data to USB FIFO
OutUsbFifoData_en  out  1  USB FIFO write enable
OutUsbStartStop  out  1  USB readout enable, high from ARM through end of FLUSH
ActiveMode  out  MODE_W  latched mode index
Busy  out  1  high in any state except IDLE
TestDone  out  1  one-cycle pulse on entering DONE
ErrorFlags  out  3  sticky: [0] invalid mode, [1] FIFO overflow/drop, [2] timeout
WordCount  out  COUNT_W  words written to FIFO in current/last run

Behaviour:
- Reset (reset_n low at a Clk edge): state IDLE. All outputs 0, all counters and flags 0. Applies mid-run too: ModeStartStop drops the next cycle, with no flush and no TestDone.
- UsbStartStop is registered once internally. Edge detection uses the registered copy, so the rising-edge response occurs 2 cycles after the input changes.
- IDLE: on a rising edge, if ModeSelect < NUM_MODES, latch ActiveMode, clear ErrorFlags and WordCount, and go to ARM. Otherwise set ErrorFlags[0] and stay in IDLE.
- ARM: exactly 1 cycle. Asserts OutUsbStartStop. Next state is RUN.
- RUN: ModeStartStop[ActiveMode]=1; all other bits are 0. The timeout counter resets on every accepted ActiveMode word and increments otherwise.
  - Falling edge of UsbStartStop -> FLUSH.
  - ModeDone[ActiveMode] high -> FLUSH.
  - Counter == TimeoutMax with TimeoutMax != 0 -> set ErrorFlags[2], go to FLUSH.
  - If a falling edge and a done occur in the same cycle, treat it as a single FLUSH entry.
- FLUSH: ModeStartStop is all 0 and data is still accepted. Lasts FLUSH_CYCLES cycles counted from entry, then DONE.
- DONE: TestDone pulses on entry and OutUsbStartStop=0. Stay in DONE until the registered UsbStartStop is 0, then go to IDLE. A host level left high never retriggers a run.
- Data path (RUN and FLUSH only):
  - An accepted word is any ModeData_en[ActiveMode]=1 cycle.
  - Data/enable of non-active engines are ignored in all states.
  - OutUsbFifoData/OutUsbFifoData_en are registered with 1-cycle latency.
  - If UsbDataFifoFull=1 in the acceptance cycle, the word is dropped (no write enable) and ErrorFlags[1] is set.
  - WordCount increments per written word and saturates at all-ones.
  - Outside RUN/FLUSH, OutUsbFifoData_en=0 and OutUsbFifoData holds its last value.
- ModeSelect changes while Busy are ignored. ActiveMode is held until the next accepted start.
- ModeDone from a non-active engine is ignored.

Test Plan:
- Reset, then UsbStartStop rises with ModeSelect=2 -> Busy=1 and OutUsbStartStop=1 two cycles later; ModeStartStop=4'b0100 one cycle after that; ActiveMode=2.
- In RUN, engine 2 sends 10 words (0x0000..0x0009) while engine 0 also toggles ModeData_en -> exactly 10 writes, each one cycle after input, values 0..9, WordCount=10.
- UsbStartStop falls; engine sends 3 more words within 16 cycles -> ModeStartStop=0, the 3 words are written, TestDone pulses 16 cycles after FLUSH entry, WordCount=13, state returns to IDLE.
- TimeoutMax=100 with no data in RUN -> ErrorFlags=3'b100 after 100 idle cycles, then FLUSH; TestDone pulses once; with the host still high, the block stays in DONE until UsbStartStop=0.
- UsbDataFifoFull=1 for 2 of 5 words -> 3 writes, ErrorFlags[1]=1; ModeSelect=5 with NUM_MODES=4 -> ErrorFlags[0]=1, Busy stays 0.
- reset_n low mid-RUN for 1 cycle -> all outputs 0 on the next edge, no TestDone; ModeDone[ActiveMode] with a simultaneous host falling edge -> a single FLUSH and a single TestDone.

Source files
------------

// File: rtl/acq_mode_sequencer_if.sv
// Bundle of host, engine and USB FIFO signals for acq_mode_sequencer.
// The slave modport is the sequencer's view; master is the driving side.
interface acq_mode_sequencer_if #(
  parameter int NUM_MODES  = 4,
  parameter int MODE_W     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT_W  = 24,
  parameter int COUNT_W    = 32
);
  logic [MODE_W-1:0]               ModeSelect;
  logic                            UsbStartStop;
  logic [TIMEOUT_W-1:0]            TimeoutMax;
  logic [NUM_MODES-1:0]            ModeStartStop;
  logic [NUM_MODES-1:0]            ModeDone;
  logic [NUM_MODES*DATA_WIDTH-1:0] ModeData;
  logic [NUM_MODES-1:0]            ModeData_en;
  logic                            UsbDataFifoFull;
  logic [DATA_WIDTH-1:0]           OutUsbFifoData;
  logic                            OutUsbFifoData_en;
  logic                            OutUsbStartStop;
  logic [MODE_W-1:0]               ActiveMode;
  logic                            Busy;
  logic                            TestDone;
  logic [2:0]                      ErrorFlags;
  logic [COUNT_W-1:0]              WordCount;

  modport slave (
    input  ModeSelect, UsbStartStop, TimeoutMax, ModeDone, ModeData, ModeData_en,
           UsbDataFifoFull,
    output ModeStartStop, OutUsbFifoData, OutUsbFifoData_en, OutUsbStartStop,
           ActiveMode, Busy, TestDone, ErrorFlags, WordCount
  );

  modport master (
    output ModeSelect, UsbStartStop, TimeoutMax, ModeDone, ModeData, ModeData_en,
           UsbDataFifoFull,
    input  ModeStartStop, OutUsbFifoData, OutUsbFifoData_en, OutUsbStartStop,
           ActiveMode, Busy, TestDone, ErrorFlags, WordCount
  );
endinterface

// File: rtl/acq_mode_sequencer.sv
// Selects one of NUM_MODES test engines per run, sequences its start/stop and
// forwards its data into the USB FIFO with flush, timeout and overflow tracking.
//
// state | meaning
// IDLE  | waiting for host rising edge
// ARM   | one cycle, USB readout enabled, engine not yet started
// RUN   | active engine started, data forwarded, timeout running
// FLUSH | engine stopped, trailing data still forwarded for FLUSH_CYCLES
// DONE  | run finished, wait for host level to drop
module acq_mode_sequencer #(
  parameter int NUM_MODES    = 4,
  parameter int MODE_W       = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int FLUSH_CYCLES = 16,
  parameter int TIMEOUT_W    = 24,
  parameter int COUNT_W      = 32
) (
  input logic Clk,
  input logic reset_n,
  acq_mode_sequencer_if.slave bus
);

  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [MODE_W:0] NUM_MODES_V = (MODE_W+1)'(NUM_MODES);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_start_q, r_start_qq;
  logic [MODE_W-1:0]     r_active;
  logic [TIMEOUT_W-1:0]  r_tmo_cnt;
  logic [FLUSH_W-1:0]    r_flush_cnt;
  logic [2:0]            r_err;
  logic [COUNT_W-1:0]    r_word_cnt;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_en;
  logic                  r_test_done;

  logic                  w_rise, w_fall, w_sel_ok, w_timeout;
  logic                  w_en_act, w_done_act, w_stop_req;
  logic [DATA_WIDTH-1:0] w_act_data;
  logic [NUM_MODES-1:0]  w_mode_ss;
  logic                  w_usb_ss, w_busy, w_xfer;

  assign w_rise     = r_start_q & ~r_start_qq;
  assign w_fall     = ~r_start_q & r_start_qq;
  assign w_sel_ok   = {1'b0, bus.ModeSelect} < NUM_MODES_V;
  assign w_timeout  = (bus.TimeoutMax != '0) && (r_tmo_cnt == bus.TimeoutMax);
  assign w_stop_req = w_fall | w_done_act;
  assign w_xfer     = (r_state == S_RUN) || (r_state == S_FLUSH);

  // Only the latched engine is ever looked at; all other lanes are don't-care.
  always_comb begin
    w_act_data = '0;
    w_en_act   = 1'b0;
    w_done_act = 1'b0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (r_active == MODE_W'(i)) begin
        w_act_data = bus.ModeData[i*DATA_WIDTH +: DATA_WIDTH];
        w_en_act   = bus.ModeData_en[i];
        w_done_act = bus.ModeDone[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_start_qq <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_q  <= bus.UsbStartStop;
      r_start_qq <= r_start_q;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_ss   = '0;
    w_usb_ss    = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_rise && w_sel_ok) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        w_usb_ss    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_usb_ss  = 1'b1;
        w_mode_ss = NUM_MODES'(1) << r_active;
        if (w_stop_req || w_timeout) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_usb_ss = 1'b1;
        if (r_flush_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!r_start_q) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_active    <= '0;
      r_tmo_cnt   <= '0;
      r_flush_cnt <= '0;
      r_err       <= '0;
      r_word_cnt  <= '0;
      r_out_data  <= '0;
      r_out_en    <= 1'b0;
      r_test_done <= 1'b0;
    end else begin
      r_out_en    <= 1'b0;
      r_test_done <= (r_state == S_FLUSH) && (w_state_nxt == S_DONE);

      if (r_state == S_IDLE && w_rise) begin
        if (w_sel_ok) begin
          r_active   <= bus.ModeSelect;
          r_err      <= '0;
          r_word_cnt <= '0;
        end else begin
          r_err[0] <= 1'b1;
        end
      end

      if (r_state == S_ARM) r_tmo_cnt <= '0;

      if (r_state == S_RUN) begin
        r_tmo_cnt <= w_en_act ? '0 : r_tmo_cnt + TIMEOUT_W'(1);
        // A simultaneous stop/done wins; the timeout flag only marks a stalled run.
        if (!w_stop_req && w_timeout) r_err[2] <= 1'b1;
        if (w_state_nxt == S_FLUSH) r_flush_cnt <= FLUSH_W'(FLUSH_CYCLES - 1);
      end

      if (r_state == S_FLUSH && r_flush_cnt != '0) r_flush_cnt <= r_flush_cnt - FLUSH_W'(1);

      if (w_xfer && w_en_act) begin
        if (bus.UsbDataFifoFull) begin
          r_err[1] <= 1'b1;
        end else begin
          r_out_en   <= 1'b1;
          r_out_data <= w_act_data;
          if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + COUNT_W'(1);
        end
      end
    end
  end

  assign bus.ModeStartStop     = w_mode_ss;
  assign bus.OutUsbStartStop   = w_usb_ss;
  assign bus.Busy              = w_busy;
  assign bus.OutUsbFifoData    = r_out_data;
  assign bus.OutUsbFifoData_en = r_out_en;
  assign bus.ActiveMode        = r_active;
  assign bus.TestDone          = r_test_done;
  assign bus.ErrorFlags        = r_err;
  assign bus.WordCount         = r_word_cnt;

endmodule

// File: tb/tb_acq_mode_sequencer.sv
// Directed bench for acq_mode_sequencer: start/run/flush, timeout, FIFO-full drops,
// invalid mode, mid-run reset and coincident stop/done.
module tb_acq_mode_sequencer;
  localparam int NUM_MODES = 4;
  localparam int MODE_W    = 3;
  localparam int DW        = 16;
  localparam int TW        = 24;
  localparam int CW        = 32;

  logic Clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  acq_mode_sequencer_if #(
    .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .DATA_WIDTH(DW), .TIMEOUT_W(TW), .COUNT_W(CW)
  ) bus ();

  acq_mode_sequencer #(
    .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .DATA_WIDTH(DW), .FLUSH_CYCLES(16),
    .TIMEOUT_W(TW), .COUNT_W(CW)
  ) dut (
    .Clk(Clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    int pulses;

    reset_n              = 1'b0;
    bus.ModeSelect       = '0;
    bus.UsbStartStop     = 1'b0;
    bus.TimeoutMax       = '0;
    bus.ModeDone         = '0;
    bus.ModeData         = '0;
    bus.ModeData_en      = '0;
    bus.UsbDataFifoFull  = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(bus.Busy), 64'(0));
    chk("rst_mss", 64'(bus.ModeStartStop), 64'(0));
    chk("rst_usbss", 64'(bus.OutUsbStartStop), 64'(0));
    chk("rst_err", 64'(bus.ErrorFlags), 64'(0));
    chk("rst_wc", 64'(bus.WordCount), 64'(0));
    reset_n = 1'b1;
    tick();

    // Run 1: mode 2, normal stop with flush
    bus.ModeSelect   = 3'd2;
    bus.UsbStartStop = 1'b1;
    tick();
    chk("start_busy_early", 64'(bus.Busy), 64'(0));
    tick();
    chk("arm_busy", 64'(bus.Busy), 64'(1));
    chk("arm_usbss", 64'(bus.OutUsbStartStop), 64'(1));
    chk("arm_mss", 64'(bus.ModeStartStop), 64'(0));
    bus.ModeSelect = 3'd0;
    tick();
    chk("run_mss", 64'(bus.ModeStartStop), 64'h4);
    chk("run_active", 64'(bus.ActiveMode), 64'(2));

    for (int i = 0; i < 10; i++) begin
      bus.ModeData[2*DW +: DW] = DW'(i);
      bus.ModeData[0*DW +: DW] = 16'hBEEF;
      bus.ModeData_en          = {1'b0, 1'b1, 1'b0, 1'(i % 2)};
      tick();
      chk("run_wr_en", 64'(bus.OutUsbFifoData_en), 64'(1));
      chk("run_wr_data", 64'(bus.OutUsbFifoData), 64'(i));
    end
    bus.ModeData_en = 4'b0001;
    tick();
    chk("other_engine_no_wr", 64'(bus.OutUsbFifoData_en), 64'(0));
    chk("run_wc10", 64'(bus.WordCount), 64'(10));

    bus.ModeData_en  = '0;
    bus.UsbStartStop = 1'b0;
    tick();
    chk("fall_still_run", 64'(bus.ModeStartStop), 64'h4);
    tick();
    chk("flush_mss", 64'(bus.ModeStartStop), 64'(0));
    chk("flush_usbss", 64'(bus.OutUsbStartStop), 64'(1));
    for (int n = 1; n <= 16; n++) begin
      bus.ModeData_en          = (n <= 3) ? 4'b0100 : 4'b0000;
      bus.ModeData[2*DW +: DW] = DW'(9 + n);
      tick();
      if (n <= 3) begin
        chk("flush_wr_en", 64'(bus.OutUsbFifoData_en), 64'(1));
        chk("flush_wr_data", 64'(bus.OutUsbFifoData), 64'(9 + n));
      end
      chk("flush_testdone", 64'(bus.TestDone), 64'(n == 16));
    end
    chk("done_usbss", 64'(bus.OutUsbStartStop), 64'(0));
    chk("done_wc13", 64'(bus.WordCount), 64'(13));
    tick();
    chk("back_idle", 64'(bus.Busy), 64'(0));
    chk("idle_td_low", 64'(bus.TestDone), 64'(0));

    // Run 2: timeout with host held high; counter 0..100 spans 101 RUN cycles
    bus.TimeoutMax   = 24'd100;
    bus.ModeSelect   = 3'd1;
    bus.UsbStartStop = 1'b1;
    tick();
    tick();
    tick();
    cnt = 0;
    while (bus.ModeStartStop != '0 && cnt < 300) begin
      cnt++;
      tick();
    end
    chk("tmo_run_cycles", 64'(cnt), 64'(101));
    chk("tmo_err", 64'(bus.ErrorFlags), 64'h4);
    chk("tmo_flush_usbss", 64'(bus.OutUsbStartStop), 64'(1));
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.TestDone) pulses++;
    end
    chk("tmo_one_testdone", 64'(pulses), 64'(1));
    chk("tmo_hold_done", 64'(bus.Busy), 64'(1));
    chk("tmo_done_usbss", 64'(bus.OutUsbStartStop), 64'(0));
    bus.UsbStartStop = 1'b0;
    tick();
    tick();
    chk("tmo_idle", 64'(bus.Busy), 64'(0));
    chk("tmo_err_sticky", 64'(bus.ErrorFlags), 64'h4);
    bus.TimeoutMax = '0;

    // Run 3: FIFO full drops 2 of 5 words
    bus.ModeSelect   = 3'd3;
    bus.UsbStartStop = 1'b1;
    tick();
    tick();
    chk("run3_err_cleared", 64'(bus.ErrorFlags), 64'(0));
    chk("run3_wc_cleared", 64'(bus.WordCount), 64'(0));
    tick();
    chk("run3_mss", 64'(bus.ModeStartStop), 64'h8);
    for (int i = 0; i < 5; i++) begin
      bus.ModeData[3*DW +: DW] = DW'(16'h0100 + i);
      bus.ModeData_en          = 4'b1000;
      bus.UsbDataFifoFull      = (i == 1 || i == 3);
      tick();
      chk("full_wr_en", 64'(bus.OutUsbFifoData_en), 64'((i == 1 || i == 3) ? 0 : 1));
    end
    bus.ModeData_en     = '0;
    bus.UsbDataFifoFull = 1'b0;
    tick();
    chk("full_wc3", 64'(bus.WordCount), 64'(3));
    chk("full_err", 64'(bus.ErrorFlags), 64'h2);
    chk("full_hold_data", 64'(bus.OutUsbFifoData), 64'h0104);
    bus.UsbStartStop = 1'b0;
    cnt = 0;
    while (bus.Busy && cnt < 60) begin
      cnt++;
      tick();
    end
    chk("run3_idle", 64'(bus.Busy), 64'(0));

    // Invalid mode select
    bus.ModeSelect   = 3'd5;
    bus.UsbStartStop = 1'b1;
    tick();
    tick();
    tick();
    chk("inv_busy", 64'(bus.Busy), 64'(0));
    chk("inv_err", 64'(bus.ErrorFlags), 64'h3);
    chk("inv_active_held", 64'(bus.ActiveMode), 64'(3));
    bus.UsbStartStop = 1'b0;
    tick();
    tick();

    // Mid-run reset
    bus.ModeSelect   = 3'd0;
    bus.UsbStartStop = 1'b1;
    tick();
    tick();
    tick();
    chk("rr_run_mss", 64'(bus.ModeStartStop), 64'h1);
    reset_n          = 1'b0;
    bus.UsbStartStop = 1'b0;
    tick();
    chk("rr_mss", 64'(bus.ModeStartStop), 64'(0));
    chk("rr_busy", 64'(bus.Busy), 64'(0));
    chk("rr_usbss", 64'(bus.OutUsbStartStop), 64'(0));
    chk("rr_td", 64'(bus.TestDone), 64'(0));
    chk("rr_err", 64'(bus.ErrorFlags), 64'(0));
    chk("rr_data", 64'(bus.OutUsbFifoData), 64'(0));
    reset_n = 1'b1;
    pulses  = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus.TestDone || bus.Busy) pulses++;
    end
    chk("rr_quiet", 64'(pulses), 64'(0));

    // Coincident done + host fall, plus non-active done ignored
    bus.ModeSelect   = 3'd1;
    bus.UsbStartStop = 1'b1;
    tick();
    tick();
    tick();
    bus.ModeDone = 4'b0001;
    tick();
    bus.ModeDone = '0;
    tick();
    chk("foreign_done_ignored", 64'(bus.ModeStartStop), 64'h2);
    bus.UsbStartStop = 1'b0;
    tick();
    bus.ModeDone = 4'b0010;
    tick();
    bus.ModeDone = '0;
    chk("dual_flush_mss", 64'(bus.ModeStartStop), 64'(0));
    chk("dual_flush_usbss", 64'(bus.OutUsbStartStop), 64'(1));
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.TestDone) pulses++;
    end
    chk("dual_one_testdone", 64'(pulses), 64'(1));
    chk("dual_idle", 64'(bus.Busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
